// File: rtl/ysyx_24100005_pkg.sv
// Shared types and constants for the ysyx_24100005 instruction fetch unit.
package ysyx_24100005_pkg;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } ifu_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
   localparam logic [31:0] NOP_INST         = 32'h0000_0013;

endpackage

// File: rtl/ysyx_24100005_ifu_pc.sv
// Architectural fetch PC: reset value, sequential +4 advance, redirect has priority.
module ysyx_24100005_ifu_pc
   import ysyx_24100005_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_redirect_valid,
   input  logic [ADDR_W-1:0] i_redirect_pc,
   input  logic              i_advance,
   output logic [ADDR_W-1:0] o_pc
);

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_next;

   // A redirect in the same cycle as a consumed instruction overrides pc+4.
   always_comb begin
      w_pc_next = r_pc;
      if (i_redirect_valid) begin
         w_pc_next = i_redirect_pc;
      end else if (i_advance) begin
         w_pc_next = r_pc + ADDR_W'(4);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pc <= RESET_PC;
      end else begin
         r_pc <= w_pc_next;
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: one outstanding word read, fetched instruction held for decode.
// Optional misaligned-PC check enabled by defining YSYX_24100005_IFU_MISALIGN_CHK_EN.
module ysyx_24100005_ifu
   import ysyx_24100005_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   output logic              o_req_valid,
   input  logic              i_req_ready,
   output logic [ADDR_W-1:0] o_req_addr,
   input  logic              i_rsp_valid,
   input  logic [DATA_W-1:0] i_rsp_data,
   input  logic              i_rsp_err,
   output logic              o_inst_valid,
   input  logic              i_inst_ready,
   output logic [DATA_W-1:0] o_inst,
   output logic [ADDR_W-1:0] o_inst_pc,
   output logic              o_inst_fault,
   input  logic              i_redirect_valid,
   input  logic [ADDR_W-1:0] i_redirect_pc
);

   ifu_state_e        r_state;
   ifu_state_e        w_state_next;
   logic              r_drop;
   logic              w_drop_next;
   logic [ADDR_W-1:0] w_pc;
   logic [ADDR_W-1:0] r_req_addr;
   logic [ADDR_W-1:0] w_req_addr;
   logic [DATA_W-1:0] r_inst;
   logic [ADDR_W-1:0] r_inst_pc;
   logic              r_inst_fault;
   logic              w_req_fire;
   logic              w_inst_fire;
   logic              w_misalign;
   logic              w_latch_rsp;
   logic              w_latch_misalign;

   ysyx_24100005_ifu_pc #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_redirect_valid (i_redirect_valid),
      .i_redirect_pc    (i_redirect_pc),
      .i_advance        (w_inst_fire),
      .o_pc             (w_pc)
   );

`ifdef YSYX_24100005_IFU_MISALIGN_CHK_EN
   // A held (dropped) request was aligned when issued, so only fresh requests are checked.
   assign w_misalign = (w_pc[1:0] != 2'b00) && !r_drop;
`else
   assign w_misalign = 1'b0;
`endif

   // Once redirected before acceptance, the original request address is frozen until it completes.
   assign w_req_addr   = (r_state == ST_REQ && r_drop) ? r_req_addr : {w_pc[ADDR_W-1:2], 2'b00};
   assign o_req_addr   = w_req_addr;
   assign o_req_valid  = !i_rst && (r_state == ST_REQ) && !w_misalign;
   assign w_req_fire   = o_req_valid && i_req_ready;
   assign o_inst_valid = (r_state == ST_HOLD);
   assign w_inst_fire  = o_inst_valid && i_inst_ready;
   assign o_inst       = r_inst;
   assign o_inst_pc    = r_inst_pc;
   assign o_inst_fault = r_inst_fault;

   always_comb begin
      w_state_next     = r_state;
      w_drop_next      = r_drop;
      w_latch_rsp      = 1'b0;
      w_latch_misalign = 1'b0;
      case (r_state)
         ST_REQ: begin
            if (w_misalign) begin
               if (!i_redirect_valid) begin
                  w_state_next     = ST_HOLD;
                  w_latch_misalign = 1'b1;
               end
            end else begin
               if (w_req_fire) begin
                  w_state_next = ST_WAIT;
               end
               if (i_redirect_valid) begin
                  w_drop_next = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (i_rsp_valid) begin
               if (r_drop || i_redirect_valid) begin
                  w_drop_next  = 1'b0;
                  w_state_next = ST_REQ;
               end else begin
                  w_latch_rsp  = 1'b1;
                  w_state_next = ST_HOLD;
               end
            end else if (i_redirect_valid) begin
               w_drop_next = 1'b1;
            end
         end
         ST_HOLD: begin
            if (i_redirect_valid || i_inst_ready) begin
               w_state_next = ST_REQ;
            end
         end
         default: begin
            w_state_next = ST_REQ;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_REQ;
         r_drop       <= 1'b0;
         r_req_addr   <= RESET_PC;
         r_inst       <= DATA_W'(NOP_INST);
         r_inst_pc    <= RESET_PC;
         r_inst_fault <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_drop     <= w_drop_next;
         r_req_addr <= w_req_addr;
         if (w_latch_rsp) begin
            r_inst       <= i_rsp_err ? DATA_W'(NOP_INST) : i_rsp_data;
            r_inst_pc    <= w_pc;
            r_inst_fault <= i_rsp_err;
         end else if (w_latch_misalign) begin
            r_inst       <= DATA_W'(NOP_INST);
            r_inst_pc    <= w_pc;
            r_inst_fault <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// Scoreboard bench for ysyx_24100005_ifu: directed scenarios followed by randomized traffic.
module tb_ysyx_24100005_ifu;

   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_data;
   logic        inst_valid, inst_ready, inst_fault;
   logic [31:0] inst, inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        fault;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] hs_pc_log[$];
   int          hs_cyc_log[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   int          mem_mode = 0;
   int          dly_min  = 0;
   int          dly_max  = 0;
   logic [31:0] model_pc;

   ysyx_24100005_ifu dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .o_req_valid      (req_valid),
      .i_req_ready      (req_ready),
      .o_req_addr       (req_addr),
      .i_rsp_valid      (rsp_valid),
      .i_rsp_data       (rsp_data),
      .i_rsp_err        (rsp_err),
      .o_inst_valid     (inst_valid),
      .i_inst_ready     (inst_ready),
      .o_inst           (inst),
      .o_inst_pc        (inst_pc),
      .o_inst_fault     (inst_fault),
      .i_redirect_valid (redirect_valid),
      .i_redirect_pc    (redirect_pc)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic timeout_fail(input string name);
      tests++;
      fails++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h8000_0000) return 32'h0000_0093;
      if (a == 32'h8000_0004) return 32'h0010_0113;
      return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
   endfunction

   function automatic logic mem_err(input logic [31:0] a);
      return (a == 32'h8000_0008) || (a[9:2] == 8'hA5);
   endfunction

   function automatic logic exp_fault(input logic [31:0] a);
`ifdef YSYX_24100005_IFU_MISALIGN_CHK_EN
      if (a[1:0] != 2'b00) return 1'b1;
`endif
      return mem_err(a);
   endfunction

   // Reference stream: each consumed instruction is the word at the fetch PC; redirects retarget.
   initial begin
      exp_t e;
      model_pc = RST_PC;
      forever begin
         @(negedge clk);
         if (rst) begin
            model_pc = RST_PC;
            exp_q.delete();
         end else begin
            if (inst_valid && inst_ready) begin
               e.pc    = model_pc;
               e.fault = exp_fault(model_pc);
               e.inst  = e.fault ? NOP : mem_word(model_pc);
               exp_q.push_back(e);
               model_pc = model_pc + 32'd4;
            end
            if (redirect_valid) model_pc = redirect_pc;
         end
      end
   end

   // Output monitor: pops the scoreboard on every instruction handshake.
   initial begin
      logic        hs;
      logic [31:0] c_inst, c_pc;
      logic        c_f;
      exp_t        e;
      forever begin
         @(negedge clk);
         hs     = !rst && inst_valid && inst_ready;
         c_inst = inst;
         c_pc   = inst_pc;
         c_f    = inst_fault;
         @(posedge clk);
         #2;
         if (hs) begin
            if (exp_q.size() == 0) begin
               timeout_fail("unexpected_inst");
            end else begin
               e = exp_q.pop_front();
               check("sb_inst", c_inst, e.inst);
               check("sb_pc", c_pc, e.pc);
               check("sb_fault", 32'(c_f), 32'(e.fault));
            end
            hs_pc_log.push_back(c_pc);
            hs_cyc_log.push_back(cyc);
         end
      end
   end

   // Handshake stability rules on both channels.
   initial begin
      logic p_rv = 1'b0, p_rr = 1'b0, p_iv = 1'b0, p_ir = 1'b0, p_rd = 1'b0, p_f = 1'b0;
      logic [31:0] p_ra = '0, p_inst = '0, p_pc = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (p_rv && !p_rr) begin
               check("req_valid_hold", 32'(req_valid), 32'd1);
               check("req_addr_hold", req_addr, p_ra);
            end
            if (p_iv && !p_ir && !p_rd) begin
               check("inst_valid_hold", 32'(inst_valid), 32'd1);
               check("inst_hold", inst, p_inst);
               check("inst_pc_hold", inst_pc, p_pc);
               check("inst_fault_hold", 32'(inst_fault), 32'(p_f));
            end
         end
         p_rv = req_valid && !rst;  p_rr = req_ready;  p_ra = req_addr;
         p_iv = inst_valid && !rst; p_ir = inst_ready; p_rd = redirect_valid;
         p_inst = inst; p_pc = inst_pc; p_f = inst_fault;
      end
   end

   // Memory model: one response per accepted request after a programmable delay.
   initial begin
      logic        mhs, pend;
      logic [31:0] maddr, paddr;
      int          pcnt;
      req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
      pend = 1'b0; paddr = '0; pcnt = 0;
      forever begin
         @(negedge clk);
         mhs   = !rst && req_valid && req_ready;
         maddr = req_addr;
         @(posedge clk);
         #1;
         rsp_valid = 1'b0;
         rsp_data  = $urandom;
         rsp_err   = 1'b0;
         if (rst) pend = 1'b0;
         if (mhs) begin
            check("one_outstanding", 32'(pend), 32'd0);
            pend  = 1'b1;
            paddr = maddr;
            pcnt  = $urandom_range(dly_max, dly_min);
         end
         if (pend) begin
            if (pcnt == 0) begin
               rsp_valid = 1'b1;
               rsp_data  = mem_word(paddr);
               rsp_err   = mem_err(paddr);
               pend      = 1'b0;
            end else begin
               pcnt--;
            end
         end
         req_ready = (mem_mode == 0) ? 1'b1 : (mem_mode == 2) ? 1'b0 : ($urandom_range(9, 0) < 7);
      end
   end

   task automatic wait_log(input int n, input string name);
      for (int i = 0; i < 100 && hs_pc_log.size() < n; i++) begin
         @(posedge clk);
         #3;
      end
      if (hs_pc_log.size() < n) timeout_fail(name);
   endtask

   task automatic wait_neg(input int kind, input string name);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         ok = (kind == 0) ? inst_valid : (kind == 1) ? (req_valid && req_ready) : req_valid;
      end
      if (!ok) timeout_fail(name);
   endtask

   task automatic redirect(input logic [31:0] target);
      @(posedge clk); #1;
      redirect_valid = 1'b1;
      redirect_pc    = target;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
   endtask

   initial begin
      int   base;
      logic saw;
      rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_valid", 32'(req_valid), 32'd0);
      check("rst_req_addr", req_addr, RST_PC);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst", inst, NOP);
      check("rst_inst_pc", inst_pc, RST_PC);
      check("rst_inst_fault", 32'(inst_fault), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      inst_ready = 1'b1;
      @(negedge clk);
      check("first_req_valid", 32'(req_valid), 32'd1);
      check("first_req_addr", req_addr, RST_PC);

      // Zero-wait stream: two instructions, three cycles apart.
      wait_log(2, "stream");
      inst_ready = 1'b0;
      if (hs_pc_log.size() >= 2) begin
         check("stream_pc0", hs_pc_log[0], 32'h8000_0000);
         check("stream_pc1", hs_pc_log[1], 32'h8000_0004);
         check("stream_gap", 32'(hs_cyc_log[1] - hs_cyc_log[0]), 32'd3);
      end

      // Backpressure on the faulting word at 0x80000008.
      wait_neg(0, "bp_wait");
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
            @(negedge clk);
         end
         check("bp_inst_valid", 32'(inst_valid), 32'd1);
         check("bp_inst", inst, NOP);
         check("bp_inst_pc", inst_pc, 32'h8000_0008);
         check("bp_fault", 32'(inst_fault), 32'd1);
         check("bp_req_valid", 32'(req_valid), 32'd0);
      end
      @(posedge clk); #1;
      inst_ready = 1'b1;
      @(posedge clk); #1;
      inst_ready = 1'b0;
      @(negedge clk);
      check("bp_next_req_valid", 32'(req_valid), 32'd1);
      check("bp_next_req_addr", req_addr, 32'h8000_000C);

      // Redirect in HOLD (not consumed), then redirect during a slow WAIT.
      dly_min = 4; dly_max = 4;
      wait_neg(0, "hold_wait");
      redirect(32'h8000_0040);
      wait_neg(1, "wait_req_hs");
      @(posedge clk); #1;
      @(posedge clk); #1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0100;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      dly_min = 0; dly_max = 0;
      saw = 1'b0;
      for (int i = 0; i < 30 && !req_valid; i++) begin
         @(negedge clk);
         saw = saw | inst_valid;
      end
      check("stale_inst_valid", 32'(saw), 32'd0);
      check("wait_redir_req_addr", req_addr, 32'h8000_0100);
      @(posedge clk); #3;
      mem_mode = 2;
      base = hs_pc_log.size();
      inst_ready = 1'b1;
      wait_log(base + 1, "wait_redir_inst");
      inst_ready = 1'b0;
      if (hs_pc_log.size() > base) check("wait_redir_inst_pc", hs_pc_log[base], 32'h8000_0100);

      // Redirect while the request is stalled by req_ready=0.
      @(negedge clk);
      check("stall_req_valid", 32'(req_valid), 32'd1);
      check("stall_req_addr", req_addr, 32'h8000_0104);
      redirect(32'h8000_0200);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_held_addr", req_addr, 32'h8000_0104);
         @(posedge clk); #1;
      end
      #2;
      mem_mode = 0;
      wait_neg(1, "stall_accept");
      check("stall_accept_addr", req_addr, 32'h8000_0104);
      @(posedge clk); #1;
      wait_neg(2, "stall_refetch");
      check("stall_refetch_addr", req_addr, 32'h8000_0200);
      base = hs_pc_log.size();
      inst_ready = 1'b1;
      wait_log(base + 1, "stall_inst");
      inst_ready = 1'b0;
      if (hs_pc_log.size() > base) check("stall_inst_pc", hs_pc_log[base], 32'h8000_0200);

      // PC wrap past the top of the address space.
      repeat (6) @(posedge clk);
      base = hs_pc_log.size();
      redirect(32'hFFFF_FFFC);
      inst_ready = 1'b1;
      wait_log(base + 2, "wrap");
      inst_ready = 1'b0;
      if (hs_pc_log.size() > base + 1) begin
         check("wrap_pc0", hs_pc_log[base], 32'hFFFF_FFFC);
         check("wrap_pc1", hs_pc_log[base + 1], 32'h0000_0000);
      end

`ifdef YSYX_24100005_IFU_MISALIGN_CHK_EN
      repeat (6) @(posedge clk);
      redirect(32'h8000_0002);
      @(negedge clk);
      check("mis_req_valid", 32'(req_valid), 32'd0);
      wait_neg(0, "mis_hold");
      check("mis_fault", 32'(inst_fault), 32'd1);
      check("mis_inst", inst, NOP);
      check("mis_inst_pc", inst_pc, 32'h8000_0002);
      redirect(32'h8000_0010);
`endif

      // Randomized traffic checked by the scoreboard.
      mem_mode = 1; dly_min = 0; dly_max = 3;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #1;
         inst_ready     = ($urandom_range(3, 0) != 0);
         redirect_valid = ($urandom_range(9, 0) == 0);
         redirect_pc    = 32'h8000_0000 + 32'($urandom_range(255, 0) << 2);
      end
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      inst_ready = 1'b1;
      mem_mode = 0; dly_max = 0;
      repeat (20) @(posedge clk);
      #3;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
